// File: rtl/store_checker_pkg.sv
// Shared types for the store checker: result codes, FSM states and an index-width helper.
package store_checker_pkg;

    typedef enum logic [1:0] {
        NONE       = 2'd0,
        WRONG_DATA = 2'd1,
        BAD_ADDR   = 2'd2,
        TIMEOUT    = 2'd3
    } fail_code_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    // A single-entry table still needs a 1-bit index.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/store_checker_table.sv
// Expected-store table: DEPTH x {address, data}, one write port, one async read port.
module store_checker_table
    import store_checker_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    localparam int IW   = idx_width(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [IW-1:0] widx,
    input  logic [AW-1:0] wadr,
    input  logic [DW-1:0] wdata,
    input  logic [IW-1:0] ridx,
    output logic [AW-1:0] radr,
    output logic [DW-1:0] rdata
);

    logic [AW-1:0] adr_mem  [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                adr_mem[i]  <= '0;
                data_mem[i] <= '0;
            end
        end else if (we) begin
            adr_mem[widx]  <= wadr;
            data_mem[widx] <= wdata;
        end
    end

    assign radr  = adr_mem[ridx];
    assign rdata = data_mem[ridx];

endmodule

// File: rtl/store_checker.sv
// Checks an observed store stream against a programmed in-order list of expected stores.
// Optional watchdog: define STORE_CHECKER_TIMEOUT_EN to fail runs that never complete.
//
// Handshake: start is a one-cycle request accepted whenever busy=0; the result
// (pass/fail plus fail_code, match_cnt, fail_adr, fail_data) is valid while pass or
// fail is high and stays stable until the next accepted start or reset.
module store_checker
    import store_checker_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024,
    parameter int IGN_LO  = 80,
    parameter int IGN_HI  = 80,
    localparam int IW     = idx_width(DEPTH),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] num_exp,
    input  logic          exp_we,
    input  logic [IW-1:0] exp_idx,
    input  logic [AW-1:0] exp_adr,
    input  logic [DW-1:0] exp_data,
    input  logic          memwrite,
    input  logic [AW-1:0] dataadr,
    input  logic [DW-1:0] writedata,
    output logic          busy,
    output logic          pass,
    output logic          fail,
    output fail_code_t    fail_code,
    output logic [CW-1:0] match_cnt,
    output logic [AW-1:0] fail_adr,
    output logic [DW-1:0] fail_data,
    output state_t        dbg_state
);

    localparam logic [AW-1:0] IGN_LO_A = AW'(IGN_LO);
    localparam logic [AW-1:0] IGN_HI_A = AW'(IGN_HI);

    state_t        state, state_nx;
    fail_code_t    code_q;
    logic [CW-1:0] cnt_q, num_q;
    logic [AW-1:0] adr_q, tbl_adr;
    logic [DW-1:0] data_q, tbl_data;
    logic          in_run, run_start, addr_hit, in_win;
    logic          st_match, st_wrong, st_bad, st_done, tmo;

    assign in_run    = (state == ST_RUN);
    assign run_start = start && !in_run;

    // The match count doubles as the pointer to the next expected entry.
    store_checker_table #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_table (
        .clk   (clk),
        .reset (reset),
        .we    (exp_we && !in_run),
        .widx  (exp_idx),
        .wadr  (exp_adr),
        .wdata (exp_data),
        .ridx  (cnt_q[IW-1:0]),
        .radr  (tbl_adr),
        .rdata (tbl_data)
    );

    assign addr_hit = (dataadr == tbl_adr);
    assign in_win   = (dataadr >= IGN_LO_A) && (dataadr <= IGN_HI_A);
    assign st_match = in_run && memwrite && addr_hit && (writedata == tbl_data);
    assign st_wrong = in_run && memwrite && addr_hit && (writedata != tbl_data);
    assign st_bad   = in_run && memwrite && !addr_hit && !in_win;
    assign st_done  = st_match && ((cnt_q + CW'(1)) == num_q);

`ifdef STORE_CHECKER_TIMEOUT_EN
    localparam int WW = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
    logic [WW-1:0] wd_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          wd_q <= '0;
        else if (run_start) wd_q <= '0;
        else if (in_run)    wd_q <= wd_q + WW'(1);
    end

    assign tmo = in_run && (wd_q == WW'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // A completing match outranks a coincident timeout.
    always_comb begin
        state_nx = state;
        case (state)
            ST_RUN: begin
                if (st_done)                         state_nx = ST_PASS;
                else if (st_wrong || st_bad || tmo)  state_nx = ST_FAIL;
            end
            default: begin
                if (start) state_nx = (num_exp == '0) ? ST_PASS : ST_RUN;
            end
        endcase
    end

    always_comb begin
        busy      = (state == ST_RUN);
        pass      = (state == ST_PASS);
        fail      = (state == ST_FAIL);
        dbg_state = state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            num_q  <= '0;
            code_q <= NONE;
            adr_q  <= '0;
            data_q <= '0;
        end else if (run_start) begin
            cnt_q  <= '0;
            num_q  <= num_exp;
            code_q <= NONE;
            adr_q  <= '0;
            data_q <= '0;
        end else if (in_run) begin
            if (st_match) cnt_q <= cnt_q + CW'(1);
            if (st_wrong || st_bad) begin
                code_q <= st_wrong ? WRONG_DATA : BAD_ADDR;
                adr_q  <= dataadr;
                data_q <= writedata;
            end else if (tmo && !st_done) begin
                code_q <= store_checker_pkg::TIMEOUT;
            end
        end
    end

    assign fail_code = code_q;
    assign match_cnt = cnt_q;
    assign fail_adr  = adr_q;
    assign fail_data = data_q;

endmodule
